sequenciador_frame_serial: RTL and testbench
============================================

SEQUENCIADOR_FRAME_SERIAL -- requirements
Module: sequenciador_frame_serial

Interface
REQ-001 SHALL have parameter N_BYTES, default 45, number of data bytes per game frame (score, ship/lives, 16 asteroid positions, 4 asteroid opcodes, 16 shot positions, 4 shot opcodes, flags, BK, terminator).
REQ-002 SHALL have parameter TIMEOUT_CICLOS, default 4095, maximum cycles to wait for tx_pronto per byte.
REQ-003 SHALL have port clock  input  1  single system clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port iniciar_transmissao  input  1  frame-start request, sampled only when idle.
REQ-006 SHALL have port byte_dados  input  8  datapath byte addressed by indice_byte, combinationally valid the same cycle.
REQ-007 SHALL have port tx_pronto  input  1  one-cycle done pulse from the UART transmitter.
REQ-008 SHALL have port indice_byte  output  6  index of the byte being fetched/sent.
REQ-009 SHALL have port tx_partida  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port db_byte_saida_serial  output  8  registered byte handed to the UART.
REQ-011 SHALL have port db_serial_ativa  output  1  high while a byte is in flight.
REQ-012 SHALL have ports ocupado  output  1  (frame in progress), pronto  output  1  (frame-done pulse), erro  output  1  (timeout pulse), db_estado  output  4  (state code).

Function
REQ-013 SHALL implement states INICIAL(0), CARREGA(1), TRANSMITE(2), ESPERA(3), PROXIMO(4), FINAL(5), ERRO(6).
REQ-014 INICIAL: indice_byte=0; iniciar_transmissao=1 -> CARREGA next edge.
REQ-015 CARREGA: latch byte_dados into db_byte_saida_serial; -> TRANSMITE.
REQ-016 TRANSMITE: tx_partida=1 for exactly one cycle, db_serial_ativa=1, clear timeout counter; -> ESPERA.
REQ-017 ESPERA: db_serial_ativa=1, timeout counter increments; tx_pronto=1 -> PROXIMO; counter reaching TIMEOUT_CICLOS without tx_pronto -> ERRO; tx_pronto wins if both in same cycle.
REQ-018 PROXIMO: db_serial_ativa=0 (guaranteed at least one low cycle between bytes); if indice_byte==N_BYTES-1 -> FINAL, else indice_byte+1 and -> CARREGA.
REQ-019 FINAL: pronto=1 one cycle, indice_byte reset to 0; -> INICIAL.
REQ-020 ERRO: erro=1 one cycle, indice_byte reset to 0; -> INICIAL; no pronto for aborted frame.
REQ-021 ocupado SHALL be 1 in every state except INICIAL; iniciar_transmissao while ocupado=1 SHALL be ignored, not queued.
REQ-022 Exactly N_BYTES tx_partida pulses and N_BYTES rising edges of db_serial_ativa SHALL occur per completed frame; first tx_partida two cycles after iniciar_transmissao is sampled.
REQ-023 tx_pronto outside ESPERA SHALL be ignored.
REQ-024 iniciar_transmissao held high across FINAL SHALL start a new frame one cycle after returning to INICIAL.

Reset
REQ-025 reset=1 SHALL immediately force INICIAL, indice_byte=0, db_byte_saida_serial=0, timeout counter=0, and tx_partida, db_serial_ativa, ocupado, pronto, erro all 0, db_estado=0.
REQ-026 reset mid-frame SHALL abandon the frame without pronto or erro; next frame restarts at byte 0.

Configuration
REQ-027 With FRAME_CHECKSUM_EN defined, SHALL keep a running XOR of every byte latched in CARREGA (cleared in INICIAL) and, after byte N_BYTES-1, send one extra byte equal to that XOR with indice_byte=N_BYTES, giving N_BYTES+1 transmissions before FINAL.
REQ-028 Without FRAME_CHECKSUM_EN, SHALL send exactly N_BYTES bytes and contain no checksum register.

Verification
REQ-029 Reset, pulse iniciar_transmissao, UART model returns tx_pronto 10 cycles after each tx_partida, byte_dados=indice -> 45 tx_partida pulses, bytes 0x00..0x2C in order, one pronto, erro never 1.
REQ-030 Hold tx_pronto low after byte 3 -> erro pulses after 4095 ESPERA cycles, pronto never asserted, next frame starts at indice_byte 0.
REQ-031 Pulse iniciar_transmissao again during byte 10 -> ignored; frame still 45 bytes, single pronto.
REQ-032 Assert reset during byte 20 -> all outputs 0 immediately; new iniciar_transmissao sends 45 bytes from index 0.
REQ-033 FRAME_CHECKSUM_EN defined, byte_dados=indice -> 46 bytes, last byte = XOR of 0x00..0x2C = 0x2C, indice_byte=45 during it.

Source files
------------

// File: rtl/sequenciador_frame_serial.sv
// Sequences one game frame of N_BYTES bytes out to a UART transmitter, one byte at a time,
// with a per-byte tx_pronto timeout. Optional feature macro: FRAME_CHECKSUM_EN (appends an XOR byte).
module sequenciador_frame_serial #(
  parameter int unsigned N_BYTES        = 45,
  parameter int unsigned TIMEOUT_CICLOS = 4095
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar_transmissao,
  input  logic [7:0] byte_dados,
  input  logic       tx_pronto,
  output logic [5:0] indice_byte,
  output logic       tx_partida,
  output logic [7:0] db_byte_saida_serial,
  output logic       db_serial_ativa,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  localparam int unsigned IDX_W = 6;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [IDX_W-1:0] IDX_ULTIMO  = IDX_W'(N_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMITE  = TMO_W'(TIMEOUT_CICLOS - 1);
`ifdef FRAME_CHECKSUM_EN
  localparam logic [IDX_W-1:0] IDX_CHECKSUM = IDX_W'(N_BYTES);
`endif

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    CARREGA   = 4'd1,
    TRANSMITE = 4'd2,
    ESPERA    = 4'd3,
    PROXIMO   = 4'd4,
    FINAL     = 4'd5,
    ERRO      = 4'd6
  } estado_t;

  estado_t          estado;
  logic [TMO_W-1:0] cont_timeout;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]       checksum;
`endif

  assign db_estado = estado;

  // Outputs are set on the edge that enters a state, so each one is valid for that whole state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado               <= INICIAL;
      indice_byte          <= '0;
      db_byte_saida_serial <= '0;
      cont_timeout         <= '0;
      tx_partida           <= 1'b0;
      db_serial_ativa      <= 1'b0;
      ocupado              <= 1'b0;
      pronto               <= 1'b0;
      erro                 <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      checksum             <= '0;
`endif
    end else begin
      tx_partida <= 1'b0;
      pronto     <= 1'b0;
      erro       <= 1'b0;

      case (estado)
        INICIAL: begin
          indice_byte  <= '0;
          cont_timeout <= '0;
`ifdef FRAME_CHECKSUM_EN
          checksum     <= '0;
`endif
          if (iniciar_transmissao) begin
            estado  <= CARREGA;
            ocupado <= 1'b1;
          end
        end

        CARREGA: begin
`ifdef FRAME_CHECKSUM_EN
          // The extra slot past the last data byte carries the running XOR instead of datapath data.
          if (indice_byte == IDX_CHECKSUM) begin
            db_byte_saida_serial <= checksum;
          end else begin
            db_byte_saida_serial <= byte_dados;
            checksum             <= checksum ^ byte_dados;
          end
`else
          db_byte_saida_serial <= byte_dados;
`endif
          estado          <= TRANSMITE;
          tx_partida      <= 1'b1;
          db_serial_ativa <= 1'b1;
        end

        TRANSMITE: begin
          cont_timeout <= '0;
          estado       <= ESPERA;
        end

        ESPERA: begin
          cont_timeout <= cont_timeout + TMO_W'(1);
          if (tx_pronto) begin
            estado          <= PROXIMO;
            db_serial_ativa <= 1'b0;
          end else if (cont_timeout == TMO_LIMITE) begin
            estado          <= ERRO;
            db_serial_ativa <= 1'b0;
            erro            <= 1'b1;
            indice_byte     <= '0;
          end
        end

        PROXIMO: begin
`ifdef FRAME_CHECKSUM_EN
          if (indice_byte == IDX_CHECKSUM) begin
            estado      <= FINAL;
            pronto      <= 1'b1;
            indice_byte <= '0;
          end else if (indice_byte == IDX_ULTIMO) begin
            estado      <= CARREGA;
            indice_byte <= IDX_CHECKSUM;
          end else begin
            estado      <= CARREGA;
            indice_byte <= indice_byte + IDX_W'(1);
          end
`else
          if (indice_byte == IDX_ULTIMO) begin
            estado      <= FINAL;
            pronto      <= 1'b1;
            indice_byte <= '0;
          end else begin
            estado      <= CARREGA;
            indice_byte <= indice_byte + IDX_W'(1);
          end
`endif
        end

        FINAL: begin
          estado  <= INICIAL;
          ocupado <= 1'b0;
        end

        ERRO: begin
          estado  <= INICIAL;
          ocupado <= 1'b0;
        end

        default: begin
          estado          <= INICIAL;
          indice_byte     <= '0;
          db_serial_ativa <= 1'b0;
          ocupado         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_frame_serial.sv
// Bench for sequenciador_frame_serial: UART responder, stream monitor and frame model.
// Honours FRAME_CHECKSUM_EN the same way as the design.
module tb_sequenciador_frame_serial;

  localparam int unsigned N_BYTES        = 45;
  localparam int unsigned TIMEOUT_CICLOS = 4095;
`ifdef FRAME_CHECKSUM_EN
  localparam int N_TX = N_BYTES + 1;
`else
  localparam int N_TX = N_BYTES;
`endif
  localparam int BUDGET = 3000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar_transmissao = 1'b0;
  logic [7:0] byte_dados;
  logic       tx_pronto;
  logic [5:0] indice_byte;
  logic       tx_partida;
  logic [7:0] db_byte_saida_serial;
  logic       db_serial_ativa;
  logic       ocupado;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;

  logic [7:0] mem [64];
  logic       uart_pronto = 1'b0;
  logic       extra_pronto = 1'b0;

  assign byte_dados = mem[indice_byte];
  assign tx_pronto  = uart_pronto | extra_pronto;

  sequenciador_frame_serial #(.N_BYTES(N_BYTES), .TIMEOUT_CICLOS(TIMEOUT_CICLOS)) dut (
    .clock(clock), .reset(reset), .iniciar_transmissao(iniciar_transmissao),
    .byte_dados(byte_dados), .tx_pronto(tx_pronto), .indice_byte(indice_byte),
    .tx_partida(tx_partida), .db_byte_saida_serial(db_byte_saida_serial),
    .db_serial_ativa(db_serial_ativa), .ocupado(ocupado), .pronto(pronto),
    .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Monitor / UART model state
  int cyc = 0, n_part = 0, n_rise = 0, n_pronto = 0, n_erro = 0;
  int cyc_pronto = 0, cyc_erro = 0;
  int uart_cd = 0, uart_lat = 10, uart_stop_idx = -1;
  bit spurious_en = 1'b0;
  logic ativa_d = 1'b0;
  logic [7:0] q_byte[$];
  logic [5:0] q_idx[$];
  int         q_cyc[$];
  logic [7:0] exp_b[$];
  logic [5:0] exp_i[$];

  // UART responds uart_lat cycles after each start; spurious pronto only while no byte is in flight.
  always @(negedge clock) begin
    cyc = cyc + 1;
    uart_pronto = 1'b0;
    if (reset) uart_cd = 0;
    if (uart_cd > 0) begin
      uart_cd = uart_cd - 1;
      if (uart_cd == 0) uart_pronto = 1'b1;
    end
    if (!reset) begin
      if (tx_partida) begin
        n_part = n_part + 1;
        q_byte.push_back(db_byte_saida_serial);
        q_idx.push_back(indice_byte);
        q_cyc.push_back(cyc);
        if (int'(indice_byte) != uart_stop_idx) uart_cd = uart_lat;
      end
      if (db_serial_ativa && !ativa_d) n_rise = n_rise + 1;
      if (pronto) begin n_pronto = n_pronto + 1; cyc_pronto = cyc; end
      if (erro) begin n_erro = n_erro + 1; cyc_erro = cyc; end
    end
    ativa_d = db_serial_ativa;
    extra_pronto = spurious_en && !db_serial_ativa && !uart_pronto && ($urandom_range(0, 3) == 0);
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_mon();
    n_part = 0; n_rise = 0; n_pronto = 0; n_erro = 0;
    q_byte.delete(); q_idx.delete(); q_cyc.delete();
  endtask

  // Frame model: data bytes in index order, then (optionally) their XOR at index N_BYTES.
  function automatic void build_expected();
    logic [7:0] x;
    x = 8'h00;
    exp_b.delete(); exp_i.delete();
    for (int i = 0; i < int'(N_BYTES); i++) begin
      exp_b.push_back(mem[i]);
      exp_i.push_back(6'(i));
      x = x ^ mem[i];
    end
`ifdef FRAME_CHECKSUM_EN
    exp_b.push_back(x);
    exp_i.push_back(6'(N_BYTES));
`else
    if (x === 8'hxx) exp_b.push_back(x);
`endif
  endfunction

  task automatic fill_mem(input bit random_data);
    for (int i = 0; i < 64; i++) mem[i] = random_data ? 8'($urandom_range(0, 255)) : 8'(i);
  endtask

  // Starts one frame and waits (bounded) until pronto or erro is seen.
  task automatic run_frame(input int retrig_idx, output bit done);
    bit retrig_done;
    retrig_done = 1'b0;
    clear_mon();
    iniciar_transmissao = 1'b1;
    step();
    iniciar_transmissao = 1'b0;
    done = 1'b0;
    for (int c = 0; c < BUDGET + int'(TIMEOUT_CICLOS) && !done; c++) begin
      step();
      if (retrig_idx >= 0 && int'(indice_byte) == retrig_idx && !retrig_done) begin
        iniciar_transmissao = 1'b1;
        step();
        iniciar_transmissao = 1'b0;
        retrig_done = 1'b1;
      end
      if (n_pronto > 0 || n_erro > 0) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({indice_byte, tx_partida, db_byte_saida_serial, db_serial_ativa, ocupado, pronto, erro, db_estado} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got idx=%0d part=%b byte=%h ativa=%b ocup=%b pronto=%b erro=%b est=%0d want all 0",
               indice_byte, tx_partida, db_byte_saida_serial, db_serial_ativa, ocupado, pronto, erro, db_estado);
    end
    reset = 1'b0;
    step();
    checks++;
    if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got est=%0d ocup=%b want 0 0", db_estado, ocupado);
    end
  endtask

  task automatic test_frame_basic();
    bit ok;
    fill_mem(1'b0); build_expected(); uart_lat = 10; spurious_en = 1'b0;
    clear_mon();
    iniciar_transmissao = 1'b1;
    step();
    iniciar_transmissao = 1'b0;
    checks++;
    if (db_estado !== 4'd1 || ocupado !== 1'b1 || tx_partida !== 1'b0) begin
      errors++; $display("FAIL carrega got est=%0d ocup=%b part=%b want 1 1 0", db_estado, ocupado, tx_partida);
    end
    step();
    checks++;
    if (db_estado !== 4'd2 || tx_partida !== 1'b1 || db_serial_ativa !== 1'b1 || db_byte_saida_serial !== 8'h00) begin
      errors++; $display("FAIL transmite got est=%0d part=%b ativa=%b byte=%h want 2 1 1 00",
                         db_estado, tx_partida, db_serial_ativa, db_byte_saida_serial);
    end
    step();
    checks++;
    if (db_estado !== 4'd3 || tx_partida !== 1'b0 || db_serial_ativa !== 1'b1) begin
      errors++; $display("FAIL espera got est=%0d part=%b ativa=%b want 3 0 1", db_estado, tx_partida, db_serial_ativa);
    end
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin step(); if (db_serial_ativa === 1'b0) ok = 1'b1; end
    checks++;
    if (!ok || db_estado !== 4'd4 || indice_byte !== 6'd0) begin
      errors++; $display("FAIL proximo got seen=%b est=%0d idx=%0d want 1 4 0", ok, db_estado, indice_byte);
    end
    step();
    checks++;
    if (db_estado !== 4'd1 || indice_byte !== 6'd1) begin
      errors++; $display("FAIL next_byte got est=%0d idx=%0d want 1 1", db_estado, indice_byte);
    end
    ok = 1'b0;
    for (int c = 0; c < BUDGET && !ok; c++) begin step(); if (n_pronto > 0 || n_erro > 0) ok = 1'b1; end
    checks++;
    if (!ok || db_estado !== 4'd5 || indice_byte !== 6'd0) begin
      errors++; $display("FAIL final got done=%b est=%0d idx=%0d want 1 5 0", ok, db_estado, indice_byte);
    end
    checks++;
    if (n_part !== N_TX || n_rise !== N_TX || n_pronto !== 1 || n_erro !== 0) begin
      errors++; $display("FAIL basic_counts got part=%0d rise=%0d pronto=%0d erro=%0d want %0d %0d 1 0",
                         n_part, n_rise, n_pronto, n_erro, N_TX, N_TX);
    end
    for (int i = 0; i < N_TX && i < q_byte.size(); i++) begin
      checks++;
      if (q_byte[i] !== exp_b[i] || q_idx[i] !== exp_i[i]) begin
        errors++; $display("FAIL basic_byte[%0d] got %h@%0d want %h@%0d", i, q_byte[i], q_idx[i], exp_b[i], exp_i[i]);
      end
    end
    step();
    checks++;
    if (db_estado !== 4'd0 || ocupado !== 1'b0 || pronto !== 1'b0) begin
      errors++; $display("FAIL back_idle got est=%0d ocup=%b pronto=%b want 0 0 0", db_estado, ocupado, pronto);
    end
  endtask

  task automatic test_random_frames();
    bit done;
    spurious_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      fill_mem(1'b1); build_expected(); uart_lat = $urandom_range(1, 15);
      run_frame(-1, done);
      checks++;
      if (!done || n_part !== N_TX || n_rise !== N_TX || n_pronto !== 1 || n_erro !== 0) begin
        errors++; $display("FAIL rand_counts[%0d] got done=%b part=%0d rise=%0d pronto=%0d erro=%0d want 1 %0d %0d 1 0",
                           f, done, n_part, n_rise, n_pronto, n_erro, N_TX, N_TX);
      end
      for (int i = 0; i < N_TX && i < q_byte.size(); i++) begin
        checks++;
        if (q_byte[i] !== exp_b[i] || q_idx[i] !== exp_i[i]) begin
          errors++; $display("FAIL rand_byte[%0d][%0d] got %h@%0d want %h@%0d", f, i, q_byte[i], q_idx[i], exp_b[i], exp_i[i]);
        end
      end
      step(); step();
    end
    spurious_en = 1'b0;
  endtask

  task automatic test_timeout();
    bit done;
    fill_mem(1'b1); build_expected(); uart_lat = 10; uart_stop_idx = 4;
    run_frame(-1, done);
    checks++;
    if (!done || n_erro !== 1 || n_pronto !== 0 || q_idx.size() != 5 || db_estado !== 4'd6) begin
      errors++; $display("FAIL timeout_abort got done=%b erro=%0d pronto=%0d sent=%0d est=%0d want 1 1 0 5 6",
                         done, n_erro, n_pronto, q_idx.size(), db_estado);
    end
    checks++;
    if (q_cyc.size() != 5 || cyc_erro - q_cyc[4] !== int'(TIMEOUT_CICLOS) + 1) begin
      errors++; $display("FAIL timeout_len got %0d want %0d", (q_cyc.size() == 5) ? cyc_erro - q_cyc[4] : -1,
                         int'(TIMEOUT_CICLOS) + 1);
    end
    uart_stop_idx = -1;
    step();
    checks++;
    if (db_estado !== 4'd0 || erro !== 1'b0 || indice_byte !== 6'd0 || ocupado !== 1'b0) begin
      errors++; $display("FAIL after_erro got est=%0d erro=%b idx=%0d ocup=%b want 0 0 0 0", db_estado, erro, indice_byte, ocupado);
    end
    run_frame(-1, done);
    checks++;
    if (!done || n_part !== N_TX || n_pronto !== 1 || n_erro !== 0 || q_idx.size() == 0 || q_idx[0] !== 6'd0) begin
      errors++; $display("FAIL restart_after_erro got done=%b part=%0d pronto=%0d erro=%0d want 1 %0d 1 0 from idx 0",
                         done, n_part, n_pronto, n_erro, N_TX);
    end
    step(); step();
  endtask

  task automatic test_ignore_start();
    bit done;
    fill_mem(1'b1); build_expected(); uart_lat = 10;
    run_frame(10, done);
    checks++;
    if (!done || n_part !== N_TX || n_pronto !== 1 || n_erro !== 0) begin
      errors++; $display("FAIL ignore_start got done=%b part=%0d pronto=%0d erro=%0d want 1 %0d 1 0",
                         done, n_part, n_pronto, n_erro, N_TX);
    end
    for (int i = 0; i < N_TX && i < q_byte.size(); i++) begin
      checks++;
      if (q_byte[i] !== exp_b[i] || q_idx[i] !== exp_i[i]) begin
        errors++; $display("FAIL ignore_byte[%0d] got %h@%0d want %h@%0d", i, q_byte[i], q_idx[i], exp_b[i], exp_i[i]);
      end
    end
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
      errors++; $display("FAIL not_queued got est=%0d ocup=%b want 0 0", db_estado, ocupado);
    end
  endtask

  task automatic test_reset_mid();
    bit done;
    bit hit;
    fill_mem(1'b1); build_expected(); uart_lat = 10;
    clear_mon();
    iniciar_transmissao = 1'b1;
    step();
    iniciar_transmissao = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < BUDGET && !hit; c++) begin step(); if (indice_byte === 6'd20 && db_serial_ativa === 1'b1) hit = 1'b1; end
    reset = 1'b1;
    #1;
    checks++;
    if (!hit || {indice_byte, tx_partida, db_byte_saida_serial, db_serial_ativa, ocupado, pronto, erro, db_estado} !== 23'd0) begin
      errors++; $display("FAIL reset_mid got hit=%b idx=%0d part=%b byte=%h ativa=%b ocup=%b est=%0d want 1 and all 0",
                         hit, indice_byte, tx_partida, db_byte_saida_serial, db_serial_ativa, ocupado, db_estado);
    end
    step(); step();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) step();
    checks++;
    if (n_pronto !== 0 || n_erro !== 0 || db_estado !== 4'd0) begin
      errors++; $display("FAIL reset_abandon got pronto=%0d erro=%0d est=%0d want 0 0 0", n_pronto, n_erro, db_estado);
    end
    run_frame(-1, done);
    checks++;
    if (!done || n_part !== N_TX || n_pronto !== 1 || n_erro !== 0) begin
      errors++; $display("FAIL after_reset_frame got done=%b part=%0d pronto=%0d erro=%0d want 1 %0d 1 0",
                         done, n_part, n_pronto, n_erro, N_TX);
    end
    for (int i = 0; i < N_TX && i < q_byte.size(); i++) begin
      checks++;
      if (q_byte[i] !== exp_b[i] || q_idx[i] !== exp_i[i]) begin
        errors++; $display("FAIL reset_byte[%0d] got %h@%0d want %h@%0d", i, q_byte[i], q_idx[i], exp_b[i], exp_i[i]);
      end
    end
    step(); step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    fill_mem(1'b1); build_expected(); uart_lat = $urandom_range(1, 8);
    clear_mon();
    iniciar_transmissao = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < BUDGET && !ok; c++) begin step(); if (q_idx.size() > N_TX) ok = 1'b1; end
    iniciar_transmissao = 1'b0;
    checks++;
    if (!ok || n_pronto !== 1 || q_cyc[N_TX] - cyc_pronto !== 3 || q_idx[N_TX] !== 6'd0) begin
      errors++; $display("FAIL b2b_restart got seen=%b pronto=%0d gap=%0d idx=%0d want 1 1 3 0",
                         ok, n_pronto, ok ? q_cyc[N_TX] - cyc_pronto : -1, ok ? q_idx[N_TX] : 6'h3f);
    end
    ok = 1'b0;
    for (int c = 0; c < BUDGET && !ok; c++) begin step(); if (n_pronto >= 2 || n_erro > 0) ok = 1'b1; end
    checks++;
    if (!ok || n_part !== 2 * N_TX || n_pronto !== 2 || n_erro !== 0) begin
      errors++; $display("FAIL b2b_counts got done=%b part=%0d pronto=%0d erro=%0d want 1 %0d 2 0",
                         ok, n_part, n_pronto, n_erro, 2 * N_TX);
    end
    for (int i = 0; i < 2 * N_TX && i < q_byte.size(); i++) begin
      checks++;
      if (q_byte[i] !== exp_b[i % N_TX] || q_idx[i] !== exp_i[i % N_TX]) begin
        errors++; $display("FAIL b2b_byte[%0d] got %h@%0d want %h@%0d", i, q_byte[i], q_idx[i], exp_b[i % N_TX], exp_i[i % N_TX]);
      end
    end
    step(); step();
  endtask

  initial begin
    fill_mem(1'b0);
    test_reset();
    test_frame_basic();
    test_random_frames();
    test_timeout();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
